// File: rtl/data_memory_arbiter_pkg.sv
// Shared constants for the data memory arbiter: bus widths, FSM state
// encoding and requester ids.
package data_memory_arbiter_pkg;

    localparam int unsigned MEM_SIZE_DEF = 262144;
    localparam int          BIT_NUMBER   = 32;
    localparam int          VECTOR_SIZE  = 64;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic REQ_LSU  = 1'b0;
    localparam logic REQ_VLSU = 1'b1;

    // Unsigned full-width range check of a word address.
    function automatic logic addr_in_range(input logic [BIT_NUMBER-1:0] addr,
                                           input logic [BIT_NUMBER-1:0] limit);
        return addr < limit;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester, response and memory-pin bundle of the data memory arbiter.
// Handshake: a requester raises reqN_valid with stable fields and holds them
// until reqN_ready is 1 in the same cycle; that cycle is the acceptance.
// rspN_valid is a one-cycle pulse qualifying rsp_rdata and rsp_error.
interface data_memory_arbiter_if;
    import data_memory_arbiter_pkg::*;

    logic                   req0_valid;
    logic                   req0_write;
    logic [BIT_NUMBER-1:0]  req0_address;
    logic [VECTOR_SIZE-1:0] req0_wdata;
    logic                   req0_ready;

    logic                   req1_valid;
    logic                   req1_write;
    logic [BIT_NUMBER-1:0]  req1_address;
    logic [VECTOR_SIZE-1:0] req1_wdata;
    logic                   req1_ready;

    logic                   rsp0_valid;
    logic                   rsp1_valid;
    logic [VECTOR_SIZE-1:0] rsp_rdata;
    logic                   rsp_error;

    logic                   mem_enable;
    logic                   mem_write_enable;
    logic [BIT_NUMBER-1:0]  mem_address;
    logic [VECTOR_SIZE-1:0] mem_data_in;
    logic [VECTOR_SIZE-1:0] mem_data_out;

    modport slave (
        input  req0_valid, req0_write, req0_address, req0_wdata,
        input  req1_valid, req1_write, req1_address, req1_wdata,
        input  mem_data_out,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_rdata, rsp_error,
        output mem_enable, mem_write_enable, mem_address, mem_data_in
    );

    modport master (
        output req0_valid, req0_write, req0_address, req0_wdata,
        output req1_valid, req1_write, req1_address, req1_wdata,
        output mem_data_out,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_rdata, rsp_error,
        input  mem_enable, mem_write_enable, mem_address, mem_data_in
    );

endinterface

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin pick. The pointer names the requester that wins a tie;
// after every grant it moves to the requester that did not win.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic       grant,
    output logic       grant_id
);

    logic ptr_q;
    logic ptr_d;

    // Pick a winner among the valid requesters, tie broken by the pointer.
    always_comb begin
        grant    = enable && (valid != 2'b00);
        grant_id = 1'b0;
        if (valid == 2'b11) begin
            grant_id = ptr_q;
        end else if (valid[1]) begin
            grant_id = 1'b1;
        end
        ptr_d = grant ? ~grant_id : ptr_q;
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one single-port data memory between the scalar LSU (requester 0)
// and the vector LSU (requester 1). One transaction every three cycles:
// IDLE (accept) -> ACCESS (memory pins driven) -> RESP (response pulse).
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int unsigned MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    data_memory_arbiter_if.slave  bus,
    output logic [1:0]            state_dbg
);

    localparam logic [BIT_NUMBER-1:0] MEM_LIMIT = BIT_NUMBER'(MEM_SIZE);

    logic [1:0]             state_q, state_d;
    logic                   write_q, write_d;
    logic                   id_q, id_d;
    logic                   err_q, err_d;
    logic                   mem_en_q, mem_en_d;
    logic                   mem_we_q, mem_we_d;
    logic [BIT_NUMBER-1:0]  mem_addr_q, mem_addr_d;
    logic [VECTOR_SIZE-1:0] mem_din_q, mem_din_d;

    logic                   arb_enable;
    logic                   grant;
    logic                   grant_id;
    logic                   sel_write;
    logic [BIT_NUMBER-1:0]  sel_addr;
    logic [VECTOR_SIZE-1:0] sel_wdata;
    logic                   sel_in_range;

    // Ready must read 0 while reset is held, even though IDLE is the reset state.
    assign arb_enable = (state_q == ST_IDLE) && reset;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .enable   (arb_enable),
        .valid    ({bus.req1_valid, bus.req0_valid}),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Route the winning requester's fields and classify its address.
    always_comb begin
        sel_write    = (grant_id == REQ_VLSU) ? bus.req1_write   : bus.req0_write;
        sel_addr     = (grant_id == REQ_VLSU) ? bus.req1_address : bus.req0_address;
        sel_wdata    = (grant_id == REQ_VLSU) ? bus.req1_wdata   : bus.req0_wdata;
        sel_in_range = addr_in_range(sel_addr, MEM_LIMIT);
    end

    // Next-state logic; memory pins are computed at acceptance so that the
    // registered copies are live exactly during ACCESS.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        id_d       = id_q;
        err_d      = err_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        mem_din_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    write_d = sel_write;
                    id_d    = grant_id;
                    err_d   = !sel_in_range;
                    if (sel_in_range) begin
                        mem_en_d   = 1'b1;
                        mem_we_d   = sel_write;
                        mem_addr_d = sel_addr;
                        mem_din_d  = sel_wdata;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, latched request and registered memory pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            id_q       <= 1'b0;
            err_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            id_q       <= id_d;
            err_q      <= err_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign bus.req0_ready       = grant && (grant_id == REQ_LSU);
    assign bus.req1_ready       = grant && (grant_id == REQ_VLSU);
    assign bus.rsp0_valid       = (state_q == ST_RESP) && (id_q == REQ_LSU);
    assign bus.rsp1_valid       = (state_q == ST_RESP) && (id_q == REQ_VLSU);
    assign bus.rsp_error        = (state_q == ST_RESP) && err_q;
    assign bus.rsp_rdata        = ((state_q == ST_RESP) && !write_q && !err_q) ?
                                  bus.mem_data_out : '0;
    assign bus.mem_enable       = mem_en_q;
    assign bus.mem_write_enable = mem_we_q;
    assign bus.mem_address      = mem_addr_q;
    assign bus.mem_data_in      = mem_din_q;
    assign state_dbg            = state_q;

endmodule
